// File: rtl/ram_ctrl_pkg.sv
// Shared types and default sizes for the single-port RAM controller.
package ram_ctrl_pkg;

  localparam int RAM_DATA_WIDTH = 64;
  localparam int RAM_ADDR_WIDTH = 12;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WRITE   = 3'd1,
    RD_ADDR = 3'd2,
    RD_CAP  = 3'd3,
    RESP    = 3'd4
  } ram_ctrl_state_t;

endpackage

// File: rtl/ram_sp_sr_sw.sv
// Single-port synchronous RAM: synchronous write, registered read, shared bidirectional data bus.
module ram_sp_sr_sw #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  clk,
  input  logic [ADDR_WIDTH-1:0] address,
  inout  wire  [DATA_WIDTH-1:0] data,
  input  logic                  cs,
  input  logic                  we,
  input  logic                  oe
);

  logic [DATA_WIDTH-1:0] mem [0:(1<<ADDR_WIDTH)-1];
  logic [DATA_WIDTH-1:0] data_out;

  always_ff @(posedge clk) begin
    if (cs && we) mem[address] <= data;
    if (cs && !we && oe) data_out <= mem[address];
  end

  // Read data appears on the bus the cycle after the address is presented.
  assign data = (cs && oe && !we) ? data_out : 'z;

endmodule

// File: rtl/ram_sp_ctrl.sv
// Request/response front end for ram_sp_sr_sw: one load or store at a time,
// sequences cs/we/oe, owns the tristate bus and returns load data.
module ram_sp_ctrl
  import ram_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = RAM_DATA_WIDTH,
  parameter int ADDR_WIDTH = RAM_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  wr_done,
  output logic [ADDR_WIDTH-1:0] ram_address,
  inout  wire  [DATA_WIDTH-1:0] ram_data,
  output logic                  ram_cs,
  output logic                  ram_we,
  output logic                  ram_oe,
  output ram_ctrl_state_t       state_o
);

  // Handshakes: a transfer happens on a rising edge where valid & ready are
  // both high; the initiator holds valid and its payload until that edge.
  ram_ctrl_state_t       state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  req_hs;

  assign req_hs = req_valid && (state_q == IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: begin
        if (req_hs) begin
          addr_d  = req_addr;
          wdata_d = req_wdata;
          state_d = req_we ? WRITE : RD_ADDR;
        end
      end
      WRITE:   state_d = IDLE;
      RD_ADDR: state_d = RD_CAP;
      RD_CAP: begin
        rdata_d = ram_data;
        state_d = RESP;
      end
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready   = 1'b0;
    rsp_valid   = 1'b0;
    wr_done     = 1'b0;
    ram_cs      = 1'b0;
    ram_we      = 1'b0;
    ram_oe      = 1'b0;
    ram_address = '0;
    case (state_q)
      IDLE:  req_ready = 1'b1;
      WRITE: begin
        ram_cs      = 1'b1;
        ram_we      = 1'b1;
        wr_done     = 1'b1;
        ram_address = addr_q;
      end
      RD_ADDR, RD_CAP: begin
        ram_cs      = 1'b1;
        ram_oe      = 1'b1;
        ram_address = addr_q;
      end
      RESP:    rsp_valid = 1'b1;
      default: ;
    endcase
  end

  // Only WRITE drives the bus, and WRITE always has oe low.
  assign ram_data  = (state_q == WRITE) ? wdata_q : 'z;
  assign rsp_rdata = rdata_q;
  assign state_o   = state_q;

endmodule

// File: doc/ram_sp_ctrl.md
# ram_sp_ctrl

Request/response front end for the single-port synchronous RAM (`ram_sp_sr_sw`, bidirectional data bus, cs/we/oe control). It sits directly upstream of the RAM and is its only master. It accepts one load or store at a time from the CPU datapath over a valid/ready handshake. It sequences the RAM control pins, owns the tristate data bus, and returns load data over a second valid/ready handshake.

## Interface
- `DATA_WIDTH`, 64: RAM word width.
- `ADDR_WIDTH`, 12: RAM address width.

- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  controller can accept a request.
- `req_we`  in  1  1 = store, 0 = load.
- `req_addr`  in  ADDR_WIDTH  word address.
- `req_wdata`  in  DATA_WIDTH  store data.
- `rsp_valid`  out  1  load data available.
- `rsp_ready`  in  1  consumer takes load data.
- `rsp_rdata`  out  DATA_WIDTH  load data.
- `wr_done`  out  1  one-cycle pulse when a store has been committed to the RAM.
- `ram_address`  out  ADDR_WIDTH  to RAM `address`.
- `ram_data`  inout  DATA_WIDTH  to RAM `data`; driven only while storing, otherwise `'z`.
- `ram_cs`, `ram_we`, `ram_oe`  out  1 each  to RAM `cs`, `we`, `oe`.

## Operation
- FSM states: IDLE, WRITE, RD_ADDR, RD_CAP, RESP.
- IDLE:
  - `req_ready`=1; all RAM controls 0; bus released.
  - A handshake (`req_valid & req_ready`) latches `req_we`, `req_addr` and `req_wdata` into internal registers.
  - On a handshake, go to WRITE if the store bit is set, else RD_ADDR.
- WRITE:
  - Drives `ram_cs`=1, `ram_we`=1, `ram_oe`=0, `ram_address`=latched address, `ram_data`=latched data.
  - The RAM commits the word on this cycle's closing edge.
  - Asserts `wr_done` for this cycle, then goes to IDLE.
- RD_ADDR: drives `ram_cs`=1, `ram_we`=0, `ram_oe`=1, latched address; bus released; then goes to RD_CAP.
- RD_CAP:
  - Keeps the RD_ADDR control values.
  - The RAM drives read data during this cycle; the controller samples `ram_data` into the `rsp_rdata` register on the closing edge.
  - Then goes to RESP.
- RESP:
  - `rsp_valid`=1; all RAM controls 0 (this is the bus turnaround cycle).
  - `rsp_rdata` holds stable until `rsp_valid & rsp_ready`; then goes to IDLE.
- `req_ready` is 1 only in IDLE, so at most one request is outstanding and ordering is strict.
- The controller never drives `ram_data` while `ram_oe`=1. At least one cycle with `ram_oe`=0 separates a read from the following write.
- Address and data are used as-is, with no arithmetic. `ram_address` is 0 in every state that does not access the RAM.

## Timing
- Reset (asynchronous, immediate): state=IDLE, `req_ready`=1, `rsp_valid`=0, `rsp_rdata`=0, `wr_done`=0, `ram_cs`/`ram_we`/`ram_oe`=0, `ram_address`=0, bus released.
- Reset asserted mid-operation:
  - An in-flight store that has not passed its WRITE edge is dropped.
  - A pending load response is discarded.
  - No control glitch is high after the reset assertion.
- Store accepted at edge N: WRITE during cycle N+1, `wr_done`=1 in cycle N+1, `req_ready`=1 again in cycle N+2. Throughput is 1 store per 2 cycles.
- Load accepted at edge N: RD_ADDR in N+1, RD_CAP in N+2, `rsp_valid`=1 from cycle N+3. Load-to-use latency is 3 cycles.
- If `rsp_ready`=1 in N+3: IDLE in N+4. Each stall cycle with `rsp_ready`=0 extends RESP by one cycle with `rsp_rdata` unchanged.
- `req_valid` high outside IDLE has no effect; the requester must hold the request until the handshake.
- A load immediately after a store to the same address returns the new data, because the write has committed before RD_ADDR.

## Structure
- Shared package `ram_ctrl_pkg`: state enum `ram_ctrl_state_t`, default `DATA_WIDTH`/`ADDR_WIDTH` constants.
- Single module, no sub-modules. The tristate driver is one continuous assign gated by (state==WRITE).
- The bench instantiates `ram_sp_ctrl` together with the real `ram_sp_sr_sw` (64×4096).

## Test plan
- Reset then idle for 3 cycles -> all RAM controls 0, `ram_data` = z, `req_ready`=1, `rsp_valid`=0.
- Store 0xA5 to addr 0x000, then load 0x000 -> `wr_done` pulse one cycle after accept; `rsp_valid` 3 cycles after load accept with `rsp_rdata`=0xA5.
- Stores 0x1234 to 0x018 and 0x123456789AB to 0x101, then loads of 0x101, 0x018, 0x000 -> responses 0x123456789AB, 0x1234, 0xA5 in order.
- Load from 0x018 with `rsp_ready` held 0 for 4 cycles -> `rsp_valid` and `rsp_rdata`=0x1234 stable for 5 cycles, `req_ready`=0 throughout, then IDLE.
- Load immediately followed by a store to 0x019 (value 0xBEEF) -> bus never driven while `ram_oe`=1; `mem[0x019]`=0xBEEF afterwards.
- `rst_n` pulsed low during RD_CAP -> outputs reset immediately; no `rsp_valid`; the next store/load of 0x000 behaves normally.
